// File: rtl/systolic_array_nxn_if.sv
// rtl/systolic_array_nxn_if.sv - job, operand and result signal bundle for systolic_array_nxn
// Purpose: groups the job request, operand beat stream and result row stream.
// Signals:
//   start, k_len, signed_mode      job request (sampled with start)
//   in_valid/in_ready, a_vec/b_vec operand beats, slice i = A[i][k], slice j = B[k][j]
//   c_valid/c_ready, c_row, c_row_idx result rows, slice j = C[r][j]
//   busy, done                     job status
// Modports: master drives requests/operands, slave is the array.
interface systolic_array_nxn_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_MAX      = 255,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
);
  localparam int KW = $clog2(K_MAX+1);
  localparam int RW = $clog2(N);

  logic                      start;
  logic [KW-1:0]             k_len;
  logic                      signed_mode;
  logic                      in_valid;
  logic                      in_ready;
  logic [N*DATA_WIDTH-1:0]   a_vec;
  logic [N*DATA_WIDTH-1:0]   b_vec;
  logic                      c_valid;
  logic                      c_ready;
  logic [N*ACC_WIDTH-1:0]    c_row;
  logic [RW-1:0]             c_row_idx;
  logic                      busy;
  logic                      done;

  modport master (
    output start, k_len, signed_mode, in_valid, a_vec, b_vec, c_ready,
    input  in_ready, c_valid, c_row, c_row_idx, busy, done
  );

  modport slave (
    input  start, k_len, signed_mode, in_valid, a_vec, b_vec, c_ready,
    output in_ready, c_valid, c_row, c_row_idx, busy, done
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// rtl/systolic_array_nxn.sv - N x N output-stationary systolic matrix multiplier
// Purpose: computes C = A x B (N x K times K x N). Each operand beat carries one
// column of A and one row of B; A flows right, B flows down, every PE keeps its
// own C element. Results are read out one row per handshake.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   bus (slave)    start/k_len/signed_mode job request, in_valid/in_ready/a_vec/b_vec
//                  operand beats, c_valid/c_ready/c_row/c_row_idx result rows, busy, done
module systolic_array_nxn #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_MAX      = 255,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_array_nxn_if.slave  bus
);
  localparam int KW = $clog2(K_MAX+1);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2*N);
  localparam int PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q;
  logic [KW-1:0] cnt_q;
  logic          sgn_q;
  logic [FW-1:0] fcnt_q;
  logic [RW-1:0] r_q;
  logic          done_q;

  logic fire;   // accepted beat this cycle
  logic run;    // PE pipeline advances and accumulates
  logic clr;    // job accepted: wipe accumulators and pipeline

  assign fire = (state_q == LOAD) && bus.in_valid;
  assign run  = (state_q == LOAD) || (state_q == FLUSH);
  assign clr  = (state_q == IDLE) && bus.start;

  function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic                  sgn);
    logic signed [PW-1:0] ps;
    logic        [PW-1:0] pu;
    ps = PW'($signed(a)) * PW'($signed(b));
    pu = PW'(a) * PW'(b);
    if (sgn) return ACC_WIDTH'(ps);
    else     return ACC_WIDTH'(pu);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.k_len == '0) ? DRAIN : LOAD;
      LOAD:    if (bus.in_valid && (cnt_q == k_q - KW'(1))) state_d = FLUSH;
      FLUSH:   if (fcnt_q == FW'(2*N-2)) state_d = DRAIN;
      DRAIN:   if (bus.c_ready && (r_q == RW'(N-1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- job bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= '0;
      sgn_q  <= 1'b0;
      cnt_q  <= '0;
      fcnt_q <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            k_q    <= bus.k_len;
            sgn_q  <= bus.signed_mode;
            cnt_q  <= '0;
            fcnt_q <= '0;
            r_q    <= '0;
          end
        end
        LOAD:  if (bus.in_valid) cnt_q <= cnt_q + KW'(1);
        FLUSH: fcnt_q <= fcnt_q + FW'(1);
        DRAIN: begin
          if (bus.c_ready) begin
            if (r_q == RW'(N-1)) begin
              r_q    <= '0;
              done_q <= 1'b1;
            end else begin
              r_q <= r_q + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- input skew
  // Row/column i is delayed i cycles so that beat k meets at PE(i,j) at k+i+j.
  logic [DATA_WIDTH-1:0] a_edge [N];
  logic [DATA_WIDTH-1:0] b_edge [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_WIDTH-1:0] a_in, b_in;
    // Bubbles and flush cycles inject zeros so they add nothing.
    assign a_in = fire ? bus.a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign b_in = fire ? bus.b_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    if (i == 0) begin : g_direct
      assign a_edge[i] = a_in;
      assign b_edge[i] = b_in;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] a_sr [i];
      logic [DATA_WIDTH-1:0] b_sr [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (clr) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (run) begin
          a_sr[0] <= a_in;
          b_sr[0] <= b_in;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end
      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end
  end

  // ---------------------------------------------------------------- PE grid
  logic [DATA_WIDTH-1:0] a_fwd [N][N-1];   // a leaving PE(i,j) toward PE(i,j+1)
  logic [DATA_WIDTH-1:0] b_fwd [N-1][N];   // b leaving PE(i,j) toward PE(i+1,j)
  logic [ACC_WIDTH-1:0]  acc_w [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_WIDTH-1:0] a_op, b_op;
      logic [ACC_WIDTH-1:0]  acc_q;

      if (j == 0) begin : g_a_edge
        assign a_op = a_edge[i];
      end else begin : g_a_link
        assign a_op = a_fwd[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_op = b_edge[j];
      end else begin : g_b_link
        assign b_op = b_fwd[i-1][j];
      end

      if (j < N-1) begin : g_a_reg
        logic [DATA_WIDTH-1:0] a_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)     a_q <= '0;
          else if (clr) a_q <= '0;
          else if (run) a_q <= a_op;
        end
        assign a_fwd[i][j] = a_q;
      end

      if (i < N-1) begin : g_b_reg
        logic [DATA_WIDTH-1:0] b_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)     b_q <= '0;
          else if (clr) b_q <= '0;
          else if (run) b_q <= b_op;
        end
        assign b_fwd[i][j] = b_q;
      end

      // Wraps modulo 2^ACC_WIDTH by construction.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     acc_q <= '0;
        else if (clr) acc_q <= '0;
        else if (run) acc_q <= acc_q + mul_ext(a_op, b_op, sgn_q);
      end
      assign acc_w[i][j] = acc_q;
    end
  end

  // ---------------------------------------------------------------- outputs
  for (genvar j = 0; j < N; j++) begin : g_out
    assign bus.c_row[j*ACC_WIDTH +: ACC_WIDTH] = (state_q == DRAIN) ? acc_w[r_q][j] : '0;
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.c_valid   = (state_q == DRAIN);
  assign bus.c_row_idx = r_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

endmodule
